// File: rtl/alu_seq_if.sv
`default_nettype none
// alu_seq_if: operand/op request and result/flag response bundle for alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             equal;
  logic             illegal_op;

  modport master (
    output in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, result, result_hi,
    input  carry_out, overflow, zero, equal, illegal_op
  );

  modport slave (
    input  in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, result, result_hi,
    output carry_out, overflow, zero, equal, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// alu_seq: registered multi-cycle ALU with valid/ready handshake and shift-add multiplier.
// Defining ALU_SEQ_DIV_EN builds the iterative unsigned divider for op 101.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic rst_n,
  alu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b101;
`endif
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic             accept;
  logic             op_is_mul;
  logic             op_is_div;
  logic             op_iter;
  logic             last_iter;

  // Iteration registers shared by multiplier and divider:
  // hi = partial product / remainder, lo = multiplier / quotient, opnd = multiplicand / divisor.
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    count;
  logic             equal_lat;

  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  logic             carry_q;
  logic             overflow_q;
  logic             zero_q;
  logic             equal_q;
  logic             illegal_q;

  assign accept    = bus.in_valid && (state == S_IDLE);
  assign op_is_mul = (bus.alu_op == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
  assign op_is_div = (bus.alu_op == OP_DIV);
`else
  assign op_is_div = 1'b0;
`endif
  assign op_iter   = op_is_mul || op_is_div;
  assign last_iter = (count == CW'(WIDTH - 1));

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry;
  logic             sc_ovf;
  logic             sc_illegal;

  assign add_full = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_full = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_full[WIDTH-1] != bus.a[WIDTH-1]);
  assign sub_ovf  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_full[WIDTH-1] != bus.a[WIDTH-1]);

  always_comb begin
    sc_result  = '0;
    sc_carry   = 1'b0;
    sc_ovf     = 1'b0;
    sc_illegal = 1'b0;
    case (bus.alu_op)
      OP_AND: sc_result = bus.a & bus.b;
      OP_OR:  sc_result = bus.a | bus.b;
      OP_NOR: sc_result = ~(bus.a | bus.b);
      OP_ADD: begin
        sc_result = add_full[WIDTH-1:0];
        sc_carry  = add_full[WIDTH];
        sc_ovf    = add_ovf;
      end
      OP_SUB: begin
        sc_result = sub_full[WIDTH-1:0];
        sc_carry  = sub_full[WIDTH];
        sc_ovf    = sub_ovf;
      end
      OP_SLT: begin
        // Signed less-than: sign of a-b, corrected when the subtract overflowed.
        sc_result = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
        sc_carry  = sub_full[WIDTH];
      end
      OP_MUL: sc_result = '0;
      default: sc_illegal = 1'b1;
    endcase
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;

  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_hi_nx;
  logic [WIDTH-1:0] div_lo_nx;
  logic             div_ge;

  // Restoring step; a zero divisor always subtracts, which yields all-ones and remainder a.
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;
  assign div_hi_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo_nx = {lo[WIDTH-2:0], div_ge};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op_is_mul) begin
            state_nx = S_MUL;
          end else if (op_is_div) begin
            state_nx = S_DIV;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (last_iter) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      count       <= '0;
      equal_lat   <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      equal_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            equal_lat <= (bus.a == bus.b);
            if (op_iter) begin
              hi    <= '0;
              count <= '0;
              lo    <= op_is_mul ? bus.b : bus.a;
              opnd  <= op_is_mul ? bus.a : bus.b;
            end else begin
              result_q    <= sc_result;
              result_hi_q <= '0;
              carry_q     <= sc_carry;
              overflow_q  <= sc_ovf;
              zero_q      <= (sc_result == '0);
              equal_q     <= (bus.a == bus.b);
              illegal_q   <= sc_illegal;
            end
          end
        end
        S_MUL: begin
          hi    <= mul_hi_nx;
          lo    <= mul_lo_nx;
          count <= count + CW'(1);
          if (last_iter) begin
            result_q    <= mul_lo_nx;
            result_hi_q <= mul_hi_nx;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= (mul_lo_nx == '0);
            equal_q     <= equal_lat;
            illegal_q   <= 1'b0;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          hi    <= div_hi_nx;
          lo    <= div_lo_nx;
          count <= count + CW'(1);
          if (last_iter) begin
            result_q    <= div_lo_nx;
            result_hi_q <= div_hi_nx;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= (div_lo_nx == '0);
            equal_q     <= equal_lat;
            illegal_q   <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = (state == S_DONE);
  assign bus.result     = result_q;
  assign bus.result_hi  = result_hi_q;
  assign bus.carry_out  = carry_q;
  assign bus.overflow   = overflow_q;
  assign bus.zero       = zero_q;
  assign bus.equal      = equal_q;
  assign bus.illegal_op = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// tb_alu_seq: directed and random self-checking bench for alu_seq against an arithmetic model.
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [W-1:0] rh,
                       output logic c, output logic o, output logic z,
                       output logic e, output logic il);
    longint sa, sb, s;
    logic [2*W-1:0] prod;
    logic [W:0] sum;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; rh = '0; c = 1'b0; o = 1'b0; il = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: r = ~(a | b);
      3'b010: begin
        sum = {1'b0, a} + {1'b0, b};
        r = sum[W-1:0];
        c = sum[W];
        s = sa + sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b111: begin
        r = (sa < sb) ? W'(1) : W'(0);
        c = (a >= b);
      end
      3'b011: begin
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = prod[W-1:0];
        rh = prod[2*W-1:W];
      end
      default: begin
`ifdef ALU_SEQ_DIV_EN
        if (b == '0) begin
          r = '1;
          rh = a;
        end else begin
          r = a / b;
          rh = a % b;
        end
`else
        il = 1'b1;
`endif
      end
    endcase
    z = (r == '0);
    e = (a == b);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke);
    logic [W-1:0] er, eh;
    logic ec, eo, ez, ee, ei;
    int lat, exp_lat;
    model(op, a, b, er, eh, ec, eo, ez, ee, ei);
    exp_lat = 1;
    if (op == 3'b011) exp_lat = W + 1;
`ifdef ALU_SEQ_DIV_EN
    if (op == 3'b101) exp_lat = W + 1;
`endif
    @(negedge clk);
    chk("in_ready_idle", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.alu_op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    if (poke) begin
      bus.alu_op = 3'b010;
      bus.a = ~a;
      bus.b = b ^ 32'h1;
    end else begin
      bus.in_valid = 1'b0;
    end
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      chk("in_ready_busy", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
      lat++;
    end
    chk("in_ready_done", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("result", 64'(bus.result), 64'(er));
    chk("result_hi", 64'(bus.result_hi), 64'(eh));
    chk("carry_out", 64'(bus.carry_out), 64'(ec));
    chk("overflow", 64'(bus.overflow), 64'(eo));
    chk("zero", 64'(bus.zero), 64'(ez));
    chk("equal", 64'(bus.equal), 64'(ee));
    chk("illegal_op", 64'(bus.illegal_op), 64'(ei));
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_released", 64'(bus.out_valid), 64'(0));
    chk("in_ready_released", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] edge_vals [5];
    logic [W-1:0] ra, rb;
    logic [2:0] rop;
    edge_vals[0] = 32'h0;
    edge_vals[1] = 32'h1;
    edge_vals[2] = 32'h7FFFFFFF;
    edge_vals[3] = 32'h80000000;
    edge_vals[4] = 32'hFFFFFFFF;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_op = 3'b000;
    bus.a = '0;
    bus.b = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_result", 64'(bus.result), 64'(0));
    chk("rst_zero", 64'(bus.zero), 64'(0));
    chk("rst_illegal", 64'(bus.illegal_op), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    issue(3'b010, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    chk("add_ovf_result", 64'(bus.result), 64'h80000000);
    chk("add_ovf_flag", 64'(bus.overflow), 64'(1));
    chk("add_ovf_carry", 64'(bus.carry_out), 64'(0));
    release_out();

    issue(3'b110, 32'd5, 32'd5, 1'b0);
    chk("sub_eq_zero", 64'(bus.zero), 64'(1));
    chk("sub_eq_equal", 64'(bus.equal), 64'(1));
    chk("sub_eq_carry", 64'(bus.carry_out), 64'(1));
    release_out();

    issue(3'b111, 32'hFFFFFFFF, 32'h1, 1'b0);
    chk("slt_neg1_1", 64'(bus.result), 64'(1));
    release_out();
    issue(3'b111, 32'h80000000, 32'h7FFFFFFF, 1'b0);
    chk("slt_min_max", 64'(bus.result), 64'(1));
    chk("slt_ovf_forced", 64'(bus.overflow), 64'(0));
    release_out();
    issue(3'b111, 32'h1, 32'hFFFFFFFF, 1'b0);
    chk("slt_1_neg1", 64'(bus.result), 64'(0));
    release_out();

    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("mul_lo", 64'(bus.result), 64'h00000001);
    chk("mul_hi", 64'(bus.result_hi), 64'hFFFFFFFE);
    release_out();

    issue(3'b010, 32'h12345678, 32'h11111111, 1'b0);
    held = bus.result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", 64'(bus.result), 64'h23456789);
      chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
    end
    chk("bp_held", 64'(bus.result), 64'(held));
    release_out();

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_op = 3'b011;
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'hFFFFFFFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_result", 64'(bus.result), 64'(0));
    chk("midrst_result_hi", 64'(bus.result_hi), 64'(0));
    chk("midrst_carry", 64'(bus.carry_out), 64'(0));
    chk("midrst_equal", 64'(bus.equal), 64'(0));
    chk("midrst_zero", 64'(bus.zero), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("midrst_no_partial", 64'(bus.out_valid), 64'(0));
    issue(3'b010, 32'd3, 32'd4, 1'b0);
    chk("post_rst_add", 64'(bus.result), 64'(7));
    release_out();

`ifdef ALU_SEQ_DIV_EN
    issue(3'b101, 32'd100, 32'd7, 1'b0);
    chk("div_q", 64'(bus.result), 64'(14));
    chk("div_r", 64'(bus.result_hi), 64'(2));
    release_out();
    issue(3'b101, 32'd9, 32'd0, 1'b0);
    chk("div0_q", 64'(bus.result), 64'hFFFFFFFF);
    chk("div0_r", 64'(bus.result_hi), 64'(9));
    release_out();
`else
    issue(3'b101, 32'd100, 32'd7, 1'b0);
    chk("nodiv_illegal", 64'(bus.illegal_op), 64'(1));
    chk("nodiv_result", 64'(bus.result), 64'(0));
    chk("nodiv_zero", 64'(bus.zero), 64'(1));
    release_out();
`endif

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      if ($urandom_range(0, 5) == 0) rb = ra;
      issue(rop, ra, rb, 1'b0);
      release_out();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
